// File: rtl/window_3x3_gen.sv
// window_3x3_gen
// Builds a sliding 3x3 pixel window from a raster-order 8-bit pixel stream.
// Two line buffers hold the previous two rows; three window columns shift
// one position older on every accepted pixel.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   pixel beat qualifier
//   in_sof     start of frame, sampled only with in_valid
//   in_pix     8-bit unsigned pixel
//   c1..c9     window: c1..c3 oldest row, c7..c9 current row,
//              lower index = older column, c9 = newest pixel
//   win_valid  c1..c9 hold a complete in-frame window (one cycle after its beat)
//   win_last   last window of the frame
module window_3x3_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic [7:0] in_pix,
  output logic [7:0] c1,
  output logic [7:0] c2,
  output logic [7:0] c3,
  output logic [7:0] c4,
  output logic [7:0] c5,
  output logic [7:0] c6,
  output logic [7:0] c7,
  output logic [7:0] c8,
  output logic [7:0] c9,
  output logic       win_valid,
  output logic       win_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col, eff_col, col_nxt;
  logic [RW-1:0] row, eff_row, row_nxt;

  logic [7:0] line1 [IMG_W];
  logic [7:0] line2 [IMG_W];
  logic [7:0] rd1, rd2;

  logic [7:0] win [9];

  // A start-of-frame beat is position (0,0) whatever the counters say.
  always_comb begin
    eff_col = in_sof ? '0 : col;
    eff_row = in_sof ? '0 : row;
    col_nxt = eff_col + CW'(1);
    row_nxt = eff_row;
    if (eff_col == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (eff_row == ROW_LAST) ? '0 : eff_row + RW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

  assign rd1 = line1[eff_col];
  assign rd2 = line2[eff_col];

  // Line buffers are not reset: every entry is rewritten during rows 0 and 1
  // of a frame before row gating lets any window that uses it out.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      line2[eff_col] <= rd1;
      line1[eff_col] <= in_pix;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) win[i] <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else begin
      if (in_valid) begin
        win[0] <= win[1];
        win[1] <= win[2];
        win[2] <= rd2;
        win[3] <= win[4];
        win[4] <= win[5];
        win[5] <= rd1;
        win[6] <= win[7];
        win[7] <= win[8];
        win[8] <= in_pix;
      end
      // Column gating keeps windows from straddling a line wrap; row gating
      // keeps rows from an abandoned frame out after a mid-frame sof.
      win_valid <= in_valid && (eff_row >= ROW_TWO) && (eff_col >= COL_TWO);
      win_last  <= in_valid && (eff_row == ROW_LAST) && (eff_col == COL_LAST);
    end
  end

  assign c1 = win[0];
  assign c2 = win[1];
  assign c3 = win[2];
  assign c4 = win[3];
  assign c5 = win[4];
  assign c6 = win[5];
  assign c7 = win[6];
  assign c8 = win[7];
  assign c9 = win[8];

endmodule
